fp_round_unit: RTL and testbench
================================

Name: fp_round_unit

Overview:
- Final rounding stage of the FP execution path. Consumes the unrounded result of FP arithmetic/magnitude units: sign, biased exponent, 23-bit fraction, guard/round/sticky bits and upstream exception flags.
- Applies the RISC-V rounding mode and produces the packed float_t result plus the 5-bit fflags vector for the FP writeback stage.
- Two-stage pipeline with valid/ready handshake and global clock-enable freeze.

Parameters:
- PIPE_STAGES, 2, number of register stages; only the value 2 is supported and elaboration asserts on any other value.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clk_en_i  in  1  global stage enable; 0 freezes all state
- valid_i  in  1  input beat valid
- ready_o  out  1  unit can accept input this cycle
- sign_i  in  1  result sign
- exponent_i  in  8  biased exponent before rounding
- fraction_i  in  23  fraction before rounding
- grs_i  in  3  {guard, round, sticky}
- round_mode_i  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes are illegal
- invalid_i  in  1  upstream invalid-operation flag
- div_zero_i  in  1  upstream divide-by-zero flag
- ovf_i  in  1  upstream exponent overflow, magnitude beyond the finite range
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output
- result_o  out  32 (float_t)  rounded result
- fflags_o  out  5  {NV, DZ, OF, UF, NX}

Behaviour:
- Clocking and reset: single clock, clk_i. rst_i is synchronous and active-high.
- Reset values: valid_o=0, result_o=0, fflags_o=0, and both stage valid bits = 0. Reset overrides clk_en_i.
- Handshake:
  - An input transfers when valid_i & ready_o.
  - An output transfers when valid_o & ready_i.
  - ready_o = clk_en_i & (!s1_valid | s1_advance).
  - s1_advance = !s2_valid | ready_i.
  - The ready chain is combinational. There are no bubbles at full throughput.
- Latency: exactly 2 cycles from input transfer to valid_o, with no backpressure. Throughput is 1 result per cycle.
- Backpressure: while valid_o & !ready_i, result_o and fflags_o hold stable. Stage 1 holds if it is full.
- clk_en_i = 0: no register updates, ready_o=0, and outputs hold their current values.
- Stage 1 (decide):
  - Registers all inputs.
  - Computes lsb = fraction[0] and inexact = |grs.
  - Computes the increment:
    - RNE: g & (r | s | lsb)
    - RTZ: 0
    - RDN: sign & inexact
    - RUP: !sign & inexact
    - RMM: g
  - Illegal round_mode: treated as RNE, and NV is set for that beat.
- Stage 2 (apply):
  - Special passthrough: if exponent == 8'hFF (NaN/inf from upstream), result = input unchanged, no increment, NX=0.
  - Normal path: {exp', frac'} = {exponent, fraction} + increment, using a 31-bit add. A fraction carry propagates into the exponent, so denormal 0x00 becomes 0x01.
  - If the add yields exp' == 8'hFF, or ovf_i is set, overflow handling applies:
    - OF=1, NX=1.
    - Result is selected by mode:
      - RNE/RMM: ±inf.
      - RTZ: ±max-finite (0x7F7FFFFF with sign).
      - RDN: +max-finite if positive, -inf if negative.
      - RUP: +inf if positive, -max-finite if negative.
  - Flags:
    - NV = invalid_i | illegal-rm.
    - DZ = div_zero_i.
    - NX = inexact | OF, except on the passthrough path.
    - UF = (exponent == 0) & inexact, i.e. tiny before rounding.
- Reset mid-operation: any in-flight beats are discarded, and no valid_o pulse is produced for them.

Decomposition:
- Shared modules package:
  - float_t (already present).
  - round_mode_t enum: RNE, RTZ, RDN, RUP, RMM.
  - fflags_t packed struct {nv, dz, of, uf, nx}.
  - Constants P_INFTY, N_INFTY, P_MAX_FINITE = 32'h7F7FFFFF, N_MAX_FINITE = 32'hFF7FFFFF.
- Sub-module: fp_round_decide, a purely combinational increment/illegal-rm decision, instantiated in stage 1 and unit-testable on its own.

Test Plan:
- RNE tie-to-even:
  - sign=0, exp=0x7F, frac=0x000001, grs=100 → result 0x3F800002, fflags NX.
  - Same input with frac=0x000000 → result 0x3F800000, fflags NX.
- Mantissa carry: exp=0x7F, frac=0x7FFFFF, grs=110, RUP, sign=0 → result 0x40000000, fflags NX only.
- Overflow by mode:
  - exp=0xFE, frac=0x7FFFFF, grs=100, RNE → 0x7F800000, fflags OF|NX.
  - ovf_i=1, sign=1, RTZ → 0xFF7FFFFF, fflags OF|NX.
  - ovf_i=1, sign=1, RDN → 0xFF800000, fflags OF|NX.
- Denormal / illegal mode:
  - exp=0x00, frac=0x000001, grs=001, RUP → 0x00000002, fflags UF|NX.
  - round_mode=101 on an exact input → RNE result, fflags NV.
- Backpressure:
  - Stream 4 beats with ready_i held 0 for 3 cycles → ready_o falls after 2 beats; no beat is lost or duplicated; order is preserved; result_o is stable while stalled.
- Reset / enable:
  - Assert rst_i with 2 beats in flight → next cycle valid_o=0 and no stale output later.
  - clk_en_i=0 for 2 cycles mid-stream → all outputs frozen and ready_o=0.

Source files
------------

// File: rtl/fp_round_unit_pkg.sv
// Shared types and constants for the FP rounding stage: packed float, RISC-V
// rounding modes, fflags layout and the overflow result selection.
package fp_round_unit_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] fraction;
    } float_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } round_mode_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int unsigned FRAC_W      = 23;
    localparam int unsigned EXP_W       = 8;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;

    localparam float_t P_INFTY      = float_t'(32'h7F80_0000);
    localparam float_t N_INFTY      = float_t'(32'hFF80_0000);
    localparam float_t P_MAX_FINITE = float_t'(32'h7F7F_FFFF);
    localparam float_t N_MAX_FINITE = float_t'(32'hFF7F_FFFF);

    // Directed modes saturate at max-finite when rounding away from infinity.
    function automatic float_t overflow_result(input round_mode_t mode, input logic sign);
        float_t res;
        res = sign ? N_INFTY : P_INFTY;
        case (mode)
            RTZ:     res = sign ? N_MAX_FINITE : P_MAX_FINITE;
            RDN:     res = sign ? N_INFTY : P_MAX_FINITE;
            RUP:     res = sign ? N_MAX_FINITE : P_INFTY;
            default: res = sign ? N_INFTY : P_INFTY;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_round_unit_decide.sv
// Combinational rounding decision: increment bit, inexact and illegal-mode
// detection for one unrounded beat.
module fp_round_decide
    import fp_round_unit_pkg::*;
(
    input  logic        sign,
    input  logic        lsb,
    input  logic [2:0]  grs,
    input  logic [2:0]  round_mode,
    output logic        increment,
    output logic        inexact,
    output logic        illegal_rm,
    output round_mode_t eff_mode
);

    logic guard_bit;
    logic round_bit;
    logic sticky_bit;

    assign guard_bit  = grs[2];
    assign round_bit  = grs[1];
    assign sticky_bit = grs[0];
    assign inexact    = |grs;

    // Reserved encodings fall back to round-to-nearest-even.
    always_comb begin
        illegal_rm = 1'b0;
        eff_mode   = RNE;
        case (round_mode)
            3'b000:  eff_mode = RNE;
            3'b001:  eff_mode = RTZ;
            3'b010:  eff_mode = RDN;
            3'b011:  eff_mode = RUP;
            3'b100:  eff_mode = RMM;
            default: illegal_rm = 1'b1;
        endcase
    end

    always_comb begin
        increment = 1'b0;
        case (eff_mode)
            RNE:     increment = guard_bit & (round_bit | sticky_bit | lsb);
            RTZ:     increment = 1'b0;
            RDN:     increment = sign & inexact;
            RUP:     increment = !sign & inexact;
            RMM:     increment = guard_bit;
            default: increment = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_unit.sv
// Two-stage FP rounding pipeline: stage 1 decides the increment, stage 2
// applies it, handles overflow/specials and packs result and fflags.
module fp_round_unit
    import fp_round_unit_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        sign_i,
    input  logic [7:0]  exponent_i,
    input  logic [22:0] fraction_i,
    input  logic [2:0]  grs_i,
    input  logic [2:0]  round_mode_i,
    input  logic        invalid_i,
    input  logic        div_zero_i,
    input  logic        ovf_i,
    output logic        valid_o,
    input  logic        ready_i,
    output float_t      result_o,
    output fflags_t     fflags_o
);

    generate
        if (PIPE_STAGES != 2) begin : g_bad_pipe_stages
            $error("fp_round_unit: PIPE_STAGES must be 2");
        end
    endgenerate

    logic        s1_valid;
    logic        s2_valid;
    logic        s1_advance;
    logic        in_fire;

    logic        d_increment;
    logic        d_inexact;
    logic        d_illegal_rm;
    round_mode_t d_mode;

    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exponent;
    logic [FRAC_W-1:0] s1_fraction;
    logic              s1_increment;
    logic              s1_inexact;
    logic              s1_nv;
    logic              s1_dz;
    logic              s1_ovf;
    round_mode_t       s1_mode;

    logic [30:0] sum;
    logic        passthrough;
    logic        overflow;
    float_t      s2_result_d;
    fflags_t     s2_flags_d;

    assign s1_advance = !s2_valid | ready_i;
    assign ready_o    = clk_en_i & (!s1_valid | s1_advance);
    assign in_fire    = valid_i & ready_o;
    assign valid_o    = s2_valid;

    fp_round_decide u_decide (
        .sign       (sign_i),
        .lsb        (fraction_i[0]),
        .grs        (grs_i),
        .round_mode (round_mode_i),
        .increment  (d_increment),
        .inexact    (d_inexact),
        .illegal_rm (d_illegal_rm),
        .eff_mode   (d_mode)
    );

    // Stage 1 captures the operand plus the rounding decision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_exponent  <= '0;
            s1_fraction  <= '0;
            s1_increment <= 1'b0;
            s1_inexact   <= 1'b0;
            s1_nv        <= 1'b0;
            s1_dz        <= 1'b0;
            s1_ovf       <= 1'b0;
            s1_mode      <= RNE;
        end else if (clk_en_i) begin
            if (!s1_valid || s1_advance) begin
                s1_valid <= valid_i;
            end
            if (in_fire) begin
                s1_sign      <= sign_i;
                s1_exponent  <= exponent_i;
                s1_fraction  <= fraction_i;
                s1_increment <= d_increment;
                s1_inexact   <= d_inexact;
                s1_nv        <= invalid_i | d_illegal_rm;
                s1_dz        <= div_zero_i;
                s1_ovf       <= ovf_i;
                s1_mode      <= d_mode;
            end
        end
    end

    // A single 31-bit add lets a fraction carry bump the exponent for free.
    always_comb begin
        sum         = {s1_exponent, s1_fraction} + {30'd0, s1_increment};
        passthrough = (s1_exponent == EXP_SPECIAL);
        overflow    = !passthrough & (s1_ovf | (sum[30:23] == EXP_SPECIAL));

        s2_result_d = {s1_sign, sum};
        if (passthrough) begin
            s2_result_d = {s1_sign, s1_exponent, s1_fraction};
        end else if (overflow) begin
            s2_result_d = overflow_result(s1_mode, s1_sign);
        end

        s2_flags_d.nv = s1_nv;
        s2_flags_d.dz = s1_dz;
        s2_flags_d.of = overflow;
        s2_flags_d.uf = (s1_exponent == '0) & s1_inexact;
        s2_flags_d.nx = !passthrough & (s1_inexact | overflow);
    end

    // Stage 2 output register; holds while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            result_o <= '0;
            fflags_o <= '0;
        end else if (clk_en_i && s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_o <= s2_result_d;
                fflags_o <= s2_flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_unit.sv
// Scoreboard bench for fp_round_unit: directed test-plan beats, randomized
// traffic against an arithmetic reference model, backpressure, reset and freeze.
module tb_fp_round_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        sign_i = 1'b0;
    logic [7:0]  exponent_i = '0;
    logic [22:0] fraction_i = '0;
    logic [2:0]  grs_i = '0;
    logic [2:0]  round_mode_i = '0;
    logic        invalid_i = 1'b0;
    logic        div_zero_i = 1'b0;
    logic        ovf_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    fp_round_unit #(.PIPE_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clk_en_i     (clk_en_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sign_i       (sign_i),
        .exponent_i   (exponent_i),
        .fraction_i   (fraction_i),
        .grs_i        (grs_i),
        .round_mode_i (round_mode_i),
        .invalid_i    (invalid_i),
        .div_zero_i   (div_zero_i),
        .ovf_i        (ovf_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .fflags_o     (fflags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic        inv;
        logic        dz;
        logic        ovf;
    } beat_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hold_cnt = 0;
    int   ready_mode = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Reference: rounding as a comparison of the discarded bits against half an ulp.
    function automatic exp_t model(input beat_t b);
        exp_t        e;
        logic        illegal;
        int          mode;
        logic        inexact;
        logic        up;
        logic        of;
        longint      mag;
        logic [31:0] maxf;
        logic [31:0] inf;
        illegal = (b.rm > 3'd4);
        mode    = illegal ? 0 : int'(b.rm);
        inexact = (b.grs != 3'd0);
        case (mode)
            0:       up = (b.grs > 3'd4) || ((b.grs == 3'd4) && b.frac[0]);
            1:       up = 1'b0;
            2:       up = b.sign && inexact;
            3:       up = !b.sign && inexact;
            default: up = (b.grs >= 3'd4);
        endcase
        maxf = {b.sign, 31'h7F7F_FFFF};
        inf  = {b.sign, 31'h7F80_0000};
        of   = 1'b0;
        if (b.exp == 8'hFF) begin
            e.res = {b.sign, b.exp, b.frac};
        end else begin
            mag = longint'({b.exp, b.frac}) + (up ? 64'd1 : 64'd0);
            of  = b.ovf || (mag >= (64'd255 << 23));
            if (of) begin
                case (mode)
                    1:       e.res = maxf;
                    2:       e.res = b.sign ? inf : maxf;
                    3:       e.res = b.sign ? maxf : inf;
                    default: e.res = inf;
                endcase
            end else begin
                e.res = {b.sign, 31'(mag)};
            end
        end
        e.fl = {illegal || b.inv, b.dz, of, (b.exp == 8'h00) && inexact,
                (b.exp != 8'hFF) && (inexact || of)};
        return e;
    endfunction

    function automatic beat_t mk(input logic s, input logic [7:0] ex, input logic [22:0] fr,
                                 input logic [2:0] g, input logic [2:0] rm,
                                 input logic inv, input logic dz, input logic ov);
        beat_t b;
        b.sign = s; b.exp = ex; b.frac = fr; b.grs = g; b.rm = rm;
        b.inv = inv; b.dz = dz; b.ovf = ov;
        return b;
    endfunction

    function automatic exp_t ex(input logic [31:0] r, input logic [4:0] f);
        exp_t e;
        e.res = r;
        e.fl  = f;
        return e;
    endfunction

    function automatic beat_t randBeat();
        beat_t b;
        b.sign = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       b.exp = 8'h00;
            1:       b.exp = 8'hFE;
            2:       b.exp = 8'hFF;
            default: b.exp = 8'($urandom);
        endcase
        b.frac = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        b.grs  = 3'($urandom);
        b.rm   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        b.inv  = ($urandom_range(0, 7) == 0);
        b.dz   = ($urandom_range(0, 7) == 0);
        b.ovf  = ($urandom_range(0, 9) == 0);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (hold_cnt > 0) begin
            ready_i = 1'b0;
            hold_cnt--;
        end else if (ready_mode == 1) begin
            ready_i = ($urandom_range(0, 3) != 0);
        end else begin
            ready_i = 1'b1;
        end
    endtask

    task automatic applyStimulus(input beat_t b, input exp_t e, output int waits);
        logic accepted;
        sign_i = b.sign; exponent_i = b.exp; fraction_i = b.frac; grs_i = b.grs;
        round_mode_i = b.rm; invalid_i = b.inv; div_zero_i = b.dz; ovf_i = b.ovf;
        valid_i  = 1'b1;
        waits    = 0;
        accepted = 1'b0;
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                sb_q.push_back(e);
                accepted = 1'b1;
            end else begin
                waits++;
            end
            tick();
        end
        valid_i = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got ready_o=0 for 64 cycles, expected acceptance");
        end
    endtask

    task automatic sendRandom(input int n);
        beat_t b;
        int    w;
        for (int i = 0; i < n; i++) begin
            b = randBeat();
            applyStimulus(b, model(b), w);
        end
    endtask

    task automatic drainPipe();
        ready_mode = 0;
        hold_cnt   = 0;
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
        checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);
        tick();
        tick();
    endtask

    // Monitor: pops on every output transfer and checks stall/freeze stability.
    logic        prev_stall = 1'b0;
    logic [37:0] prev_out;
    exp_t        mon_e;

    always @(negedge clk_i) begin
        if (prev_stall) begin
            checkOutput("hold_stable", 64'({valid_o, result_o, fflags_o}), 64'(prev_out));
        end
        if (!rst_i && clk_en_i && valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got result %h, expected no output", result_o);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("result", 64'(result_o), 64'(mon_e.res));
                checkOutput("fflags", 64'(fflags_o), 64'(mon_e.fl));
            end
        end
        prev_stall = !rst_i && (!clk_en_i || (valid_o && !ready_i));
        prev_out   = {valid_o, result_o, fflags_o};
    end

    initial begin
        int          w;
        beat_t       b;
        logic [37:0] frozen;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_valid", 64'(valid_o), 64'd0);
        checkOutput("reset_result", 64'(result_o), 64'd0);
        checkOutput("reset_fflags", 64'(fflags_o), 64'd0);
        rst_i = 1'b0;
        tick();

        applyStimulus(mk(0, 8'h7F, 23'h000001, 3'b100, 3'd0, 0, 0, 0), ex(32'h3F800002, 5'b00001), w);
        applyStimulus(mk(0, 8'h7F, 23'h000000, 3'b100, 3'd0, 0, 0, 0), ex(32'h3F800000, 5'b00001), w);
        applyStimulus(mk(0, 8'h7F, 23'h7FFFFF, 3'b110, 3'd3, 0, 0, 0), ex(32'h40000000, 5'b00001), w);
        applyStimulus(mk(0, 8'hFE, 23'h7FFFFF, 3'b100, 3'd0, 0, 0, 0), ex(32'h7F800000, 5'b00101), w);
        applyStimulus(mk(1, 8'h90, 23'h000000, 3'b000, 3'd1, 0, 0, 1), ex(32'hFF7FFFFF, 5'b00101), w);
        applyStimulus(mk(1, 8'h90, 23'h000000, 3'b000, 3'd2, 0, 0, 1), ex(32'hFF800000, 5'b00101), w);
        applyStimulus(mk(0, 8'h90, 23'h000000, 3'b000, 3'd2, 0, 0, 1), ex(32'h7F7FFFFF, 5'b00101), w);
        applyStimulus(mk(1, 8'h90, 23'h000000, 3'b000, 3'd3, 0, 0, 1), ex(32'hFF7FFFFF, 5'b00101), w);
        applyStimulus(mk(0, 8'h00, 23'h000001, 3'b001, 3'd3, 0, 0, 0), ex(32'h00000002, 5'b00011), w);
        applyStimulus(mk(0, 8'h85, 23'h123456, 3'b000, 3'd5, 0, 0, 0), ex(32'h42923456, 5'b10000), w);
        applyStimulus(mk(0, 8'hFF, 23'h400000, 3'b111, 3'd3, 1, 0, 0), ex(32'h7FC00000, 5'b10000), w);
        applyStimulus(mk(0, 8'h7F, 23'h000000, 3'b100, 3'd4, 0, 0, 0), ex(32'h3F800001, 5'b00001), w);
        applyStimulus(mk(1, 8'h80, 23'h000000, 3'b000, 3'd0, 0, 1, 0), ex(32'hC0000000, 5'b01000), w);
        drainPipe();

        ready_mode = 1;
        sendRandom(300);
        drainPipe();

        // Four beats against a consumer stalled for three cycles.
        ready_i  = 1'b0;
        hold_cnt = 3;
        b = randBeat(); applyStimulus(b, model(b), w);
        b = randBeat(); applyStimulus(b, model(b), w);
        b = randBeat(); applyStimulus(b, model(b), w);
        checkOutput("bp_third_beat_waits", 64'(w), 64'd2);
        b = randBeat(); applyStimulus(b, model(b), w);
        drainPipe();

        // Two beats in flight, then reset.
        ready_i  = 1'b0;
        hold_cnt = 100;
        sendRandom(2);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("midreset_valid", 64'(valid_o), 64'd0);
        checkOutput("midreset_result", 64'(result_o), 64'd0);
        sb_q.delete();
        rst_i    = 1'b0;
        hold_cnt = 0;
        ready_i  = 1'b1;
        tick();
        sendRandom(3);
        drainPipe();

        // Freeze the pipeline for two cycles mid-stream.
        sendRandom(3);
        clk_en_i = 1'b0;
        @(negedge clk_i);
        checkOutput("freeze_ready0", 64'(ready_o), 64'd0);
        frozen = {valid_o, result_o, fflags_o};
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkOutput("freeze_ready1", 64'(ready_o), 64'd0);
        checkOutput("freeze_outputs", 64'({valid_o, result_o, fflags_o}), 64'(frozen));
        @(posedge clk_i);
        #1;
        clk_en_i = 1'b1;
        sendRandom(4);
        ready_mode = 1;
        sendRandom(40);
        drainPipe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
